aes_cbc_apb_ctrl: RTL and testbench
===================================

Name: aes_cbc_apb_ctrl

Overview:
- APB slave controller that sequences a shared external AES datapath over NCTX independent key/IV contexts.
- Modes: ECB or CBC, encrypt or decrypt.
- Chaining (IV update) is done inside the block, so software streams blocks back-to-back by rewriting only DIN and START.
- Sits between the APB bus and an AES core with a single ld/done handshake.

Parameters:
- PINDEX, 0: bit of vpsel that selects this slave.
- NAPBSLV, 8: width of vpsel.
- NCTX, 2: number of key/IV contexts, 1..4.

Ports:
- vclk  in  1  clock, all logic on rising edge.
- vrstn  in  1  asynchronous, active-low reset.
- vpsel  in  NAPBSLV  APB slave selects.
- vpenable  in  1  APB strobe.
- vpaddr  in  32  byte address; only [7:2] decoded.
- vpwrite  in  1  APB write.
- vpwdata  in  32  write data.
- vprdata  out  32  read data.
- core_ld  out  1  one-cycle load pulse to the AES core.
- core_dec  out  1  1 = inverse cipher; held stable through the operation.
- core_key  out  128  key of the active context, word0 at [127:96].
- core_text_in  out  128  core input block.
- core_done  in  1  one-cycle completion pulse.
- core_text_out  in  128  core result, valid when core_done=1.
- irq  out  1  interrupt (see Optional Feature).

Behaviour:
- Register map, word offsets within the block:
  - Context c at c*0x20: KEY0..3 at +0x00..0x0C, IV0..3 at +0x10..0x1C.
  - DIN0..3 at 0x80..0x8C.
  - DOUT0..3 at 0x90..0x9C, read-only.
  - CTRL at 0xA0; STATUS at 0xA4.
  - Unmapped addresses and contexts >= NCTX: reads return 0, writes are ignored.
- APB write: performed when vpsel[PINDEX] & vpenable & vpwrite; zero wait states.
- APB read: vprdata is combinational from vpaddr when vpsel[PINDEX]=1, else 0.
- CTRL fields:
  - [0] START: write-1 pulse, always reads 0.
  - [1] DEC.
  - [2] CBC (0 = ECB).
  - [5:4] CTX.
  - [8] IRQEN.
  - Other bits read 0.
- STATUS fields:
  - [0] BUSY.
  - [1] DONE: sticky, write-1-to-clear.
  - [2] ERR: sticky, write-1-to-clear.
- Reset values:
  - All registers, DOUT and FSM state are 0; FSM is in IDLE.
  - core_ld=0, core_dec=0, irq=0, vprdata=0.
- FSM states and transitions:
  - IDLE: a CTRL write with START=1 and CTX<NCTX latches DEC/CBC/CTX, sets BUSY and clears DONE on the next edge, then goes to LOAD. If CTX>=NCTX, ERR is set and the FSM stays in IDLE.
  - LOAD: core_ld=1 for exactly this cycle.
    - core_text_in = DIN ^ IV[ctx] for CBC encrypt; DIN otherwise.
    - For CBC decrypt, DIN is captured into a 128-bit hold register.
    - Next state is WAIT.
  - WAIT: core_ld=0; stay until core_done=1, then go to UPDATE.
    - core_text_out is captured into DOUT on the core_done edge.
    - For CBC decrypt, DOUT = core_text_out ^ IV[ctx].
  - UPDATE (one cycle): performs the CBC IV update, clears BUSY, sets DONE, returns to IDLE.
    - CBC encrypt: IV[ctx] <= DOUT.
    - CBC decrypt: IV[ctx] <= held DIN.
    - ECB: IVs unchanged.
- Latency: START write edge to core_ld = 1 cycle. core_done edge to DONE = 2 cycles (capture + UPDATE).
- While BUSY:
  - Writes to DIN, CTRL.START, and KEY/IV of the active context are ignored and set ERR.
  - Writes to other contexts are accepted.
- Simultaneous events:
  - A W1C of DONE in the same cycle as UPDATE: set wins, DONE=1.
  - A W1C of ERR in the same cycle as a new error: set wins.
- A core_done outside WAIT is ignored.
- Reset assertion mid-operation aborts immediately: all state returns to reset values and the core output is discarded.

Optional Feature:
- Macro: AES_CBC_IRQ_EN.
- Defined: irq is registered and equals CTRL.IRQEN & (DONE | ERR); it deasserts one cycle after the W1C.
- Undefined: irq is tied 0, CTRL[8] reads 0 and is not stored.

Test Plan:
- ECB encrypt, ctx0:
  - Stimulus: KEY = 00010203_04050607_08090a0b_0c0d0e0f, DIN = 00112233_44556677_8899aabb_ccddeeff, CTRL = 0x01; bench core model.
  - Required: core_ld one cycle after the write; DOUT = 69c4e0d8_6a7b0430_d8cdb780_70b4c55a; STATUS = 0x2.
- CBC encrypt chaining, ctx1:
  - Stimulus: IV = 0, same key/DIN, CTRL = 0x15.
  - Required: DOUT = 69c4e0d8...; IV1 now reads that value.
  - Second START with the same DIN: core_text_in = DIN ^ 69c4e0d8...
- CBC decrypt:
  - Stimulus: DIN = 69c4e0d8_6a7b0430_d8cdb780_70b4c55a, IV = 0, CTRL = 0x07.
  - Required: DOUT = 00112233_44556677_8899aabb_ccddeeff; IV0 = 69c4e0d8...
- Errors:
  - START while BUSY -> ERR=1, no second core_ld.
  - CTRL with CTX=3 when NCTX=2 -> ERR=1, BUSY stays 0.
  - W1C 0x4 -> ERR=0.
- Abort and race:
  - vrstn low during WAIT -> all registers 0; a later core_done is ignored.
  - DONE W1C in the UPDATE cycle -> DONE reads 1.
- IRQ (with AES_CBC_IRQ_EN):
  - IRQEN=1, complete one operation -> irq=1.
  - W1C DONE -> irq=0 on the next cycle.
  - Build without the macro -> irq constantly 0.

Source files
------------

// File: rtl/aes_cbc_apb_ctrl.sv
// APB-programmed ECB/CBC sequencer for a shared external AES core over NCTX key/IV contexts.
// Optional interrupt output enabled by defining AES_CBC_IRQ_EN.
module aes_cbc_apb_ctrl #(
  parameter int unsigned PINDEX  = 0,
  parameter int unsigned NAPBSLV = 8,
  parameter int unsigned NCTX    = 2
) (
  input  logic               vclk,
  input  logic               vrstn,
  input  logic [NAPBSLV-1:0] vpsel,
  input  logic               vpenable,
  input  logic [31:0]        vpaddr,
  input  logic               vpwrite,
  input  logic [31:0]        vpwdata,
  output logic [31:0]        vprdata,
  output logic               core_ld,
  output logic               core_dec,
  output logic [127:0]       core_key,
  output logic [127:0]       core_text_in,
  input  logic               core_done,
  input  logic [127:0]       core_text_out,
  output logic               irq
);

  localparam int unsigned MAXCTX   = 4;
  localparam logic [5:0]  A_CTRL   = 6'd40;
  localparam logic [5:0]  A_STATUS = 6'd41;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_UPDATE} state_t;
  state_t state_q, state_d;

  logic [31:0]  key_q [MAXCTX][4];
  logic [31:0]  iv_q  [MAXCTX][4];
  logic [31:0]  din_q [4];
  logic [127:0] dout_q, hold_q, text_q;
  logic         ctl_dec_q, ctl_cbc_q, op_dec_q, op_cbc_q;
  logic [1:0]   ctl_ctx_q, op_ctx_q;
  logic         done_q, err_q, ld_q, irqen_rd;

  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
    case (i)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

  logic [5:0]   idx;
  logic         wr, busy, wr_keyiv, keyiv_blocked, wr_din, wr_ctrl, wr_stat;
  logic         start_req, start_ok, err_set;
  logic [127:0] din_w, iv_start, iv_act, start_text;

  assign idx           = vpaddr[7:2];
  assign wr            = vpsel[PINDEX] & vpenable & vpwrite;
  assign busy          = (state_q != S_IDLE);
  assign wr_keyiv      = wr & ~idx[5] & (32'(idx[4:3]) < NCTX);
  assign keyiv_blocked = busy & (idx[4:3] == op_ctx_q);
  assign wr_din        = wr & (idx[5:2] == 4'b1000);
  assign wr_ctrl       = wr & (idx == A_CTRL);
  assign wr_stat       = wr & (idx == A_STATUS);
  assign start_req     = wr_ctrl & vpwdata[0];
  assign start_ok      = start_req & ~busy & (32'(vpwdata[5:4]) < NCTX);
  // Busy-time protected writes and out-of-range contexts both raise ERR
  assign err_set       = (busy & (wr_din | start_req | (wr_keyiv & keyiv_blocked)))
                       | (start_req & ~busy & ~start_ok);

  assign din_w      = {din_q[0], din_q[1], din_q[2], din_q[3]};
  assign iv_start   = {iv_q[vpwdata[5:4]][0], iv_q[vpwdata[5:4]][1],
                       iv_q[vpwdata[5:4]][2], iv_q[vpwdata[5:4]][3]};
  assign iv_act     = {iv_q[op_ctx_q][0], iv_q[op_ctx_q][1], iv_q[op_ctx_q][2], iv_q[op_ctx_q][3]};
  assign start_text = (vpwdata[2] & ~vpwdata[1]) ? (din_w ^ iv_start) : din_w;

  always_ff @(posedge vclk or negedge vrstn) begin
    if (!vrstn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_LOAD;
      S_LOAD:   state_d = S_WAIT;
      S_WAIT:   if (core_done) state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Register file, operation latches, result capture and IV chaining
  always_ff @(posedge vclk or negedge vrstn) begin
    if (!vrstn) begin
      for (int unsigned c = 0; c < MAXCTX; c++) begin
        for (int unsigned k = 0; k < 4; k++) begin
          key_q[c][k] <= '0;
          iv_q[c][k]  <= '0;
        end
      end
      for (int unsigned k = 0; k < 4; k++) din_q[k] <= '0;
      dout_q    <= '0;
      hold_q    <= '0;
      text_q    <= '0;
      ctl_dec_q <= 1'b0;
      ctl_cbc_q <= 1'b0;
      ctl_ctx_q <= '0;
      op_dec_q  <= 1'b0;
      op_cbc_q  <= 1'b0;
      op_ctx_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      if (wr_keyiv && !keyiv_blocked) begin
        if (idx[2]) iv_q[idx[4:3]][idx[1:0]]  <= vpwdata;
        else        key_q[idx[4:3]][idx[1:0]] <= vpwdata;
      end
      if (wr_din && !busy) din_q[idx[1:0]] <= vpwdata;
      if (wr_ctrl && !(busy && vpwdata[0])) begin
        ctl_dec_q <= vpwdata[1];
        ctl_cbc_q <= vpwdata[2];
        ctl_ctx_q <= vpwdata[5:4];
      end
      if (start_ok) begin
        op_dec_q <= vpwdata[1];
        op_cbc_q <= vpwdata[2];
        op_ctx_q <= vpwdata[5:4];
        text_q   <= start_text;
      end
      if (state_q == S_LOAD && op_cbc_q && op_dec_q) hold_q <= din_w;
      if (state_q == S_WAIT && core_done)
        dout_q <= (op_cbc_q && op_dec_q) ? (core_text_out ^ iv_act) : core_text_out;
      if (state_q == S_UPDATE && op_cbc_q) begin
        for (int unsigned k = 0; k < 4; k++)
          iv_q[op_ctx_q][k] <= word_of(op_dec_q ? hold_q : dout_q, 2'(k));
      end
      done_q <= (done_q & ~(wr_stat & vpwdata[1]) & ~start_ok) | (state_q == S_UPDATE);
      err_q  <= (err_q & ~(wr_stat & vpwdata[2])) | err_set;
      ld_q   <= (state_d == S_LOAD);
    end
  end

`ifdef AES_CBC_IRQ_EN
  logic irqen_q, irq_q;
  always_ff @(posedge vclk or negedge vrstn) begin
    if (!vrstn) begin
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_ctrl && !(busy && vpwdata[0])) irqen_q <= vpwdata[8];
      irq_q <= irqen_q & (done_q | err_q);
    end
  end
  assign irqen_rd = irqen_q;
  assign irq      = irq_q;
`else
  assign irqen_rd = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    vprdata = '0;
    if (vpsel[PINDEX]) begin
      if (!idx[5])                 vprdata = idx[2] ? iv_q[idx[4:3]][idx[1:0]] : key_q[idx[4:3]][idx[1:0]];
      else if (idx[5:2] == 4'b1000) vprdata = din_q[idx[1:0]];
      else if (idx[5:2] == 4'b1001) vprdata = word_of(dout_q, idx[1:0]);
      else if (idx == A_CTRL)      vprdata = {23'd0, irqen_rd, 2'b00, ctl_ctx_q, 1'b0, ctl_cbc_q, ctl_dec_q, 1'b0};
      else if (idx == A_STATUS)    vprdata = {29'd0, err_q, done_q, busy};
    end
  end

  assign core_ld      = ld_q;
  assign core_dec     = op_dec_q;
  assign core_text_in = text_q;
  assign core_key     = {key_q[op_ctx_q][0], key_q[op_ctx_q][1], key_q[op_ctx_q][2], key_q[op_ctx_q][3]};

  logic unused_bits;
  assign unused_bits = ^{vpaddr, vpsel, vpwdata};

endmodule

// File: tb/tb_aes_cbc_apb_ctrl.sv
// Directed bench for aes_cbc_apb_ctrl with a behavioural AES core stand-in and result scoreboards.
module tb_aes_cbc_apb_ctrl;

  localparam int unsigned NAPBSLV = 8;
  localparam int unsigned NCTX    = 2;
  localparam int          DELAY   = 10;
  localparam logic [127:0] K  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [31:0] A_DIN = 32'h80, A_DOUT = 32'h90, A_CTRL = 32'hA0, A_STATUS = 32'hA4;

  logic               vclk = 1'b0;
  logic               vrstn = 1'b0;
  logic [NAPBSLV-1:0] vpsel = '0;
  logic               vpenable = 1'b0;
  logic [31:0]        vpaddr = '0;
  logic               vpwrite = 1'b0;
  logic [31:0]        vpwdata = '0;
  logic [31:0]        vprdata;
  logic               core_ld, core_dec, irq;
  logic [127:0]       core_key, core_text_in;
  logic               core_done = 1'b0;
  logic [127:0]       core_text_out = '0;

  int   checks = 0, errors = 0;
  int   ld_count = 0, inject_req = 0, inject_ack = 0;
  logic irq_seen = 1'b0;

  typedef struct packed {
    logic [127:0] text;
    logic [127:0] key;
    logic         dec;
  } ld_exp_t;
  ld_exp_t      ld_exp_q[$];
  logic [127:0] dout_exp_q[$];

  aes_cbc_apb_ctrl #(.PINDEX(0), .NAPBSLV(NAPBSLV), .NCTX(NCTX)) dut (
    .vclk(vclk), .vrstn(vrstn), .vpsel(vpsel), .vpenable(vpenable), .vpaddr(vpaddr),
    .vpwrite(vpwrite), .vpwdata(vpwdata), .vprdata(vprdata), .core_ld(core_ld),
    .core_dec(core_dec), .core_key(core_key), .core_text_in(core_text_in),
    .core_done(core_done), .core_text_out(core_text_out), .irq(irq)
  );

  always #5 vclk = ~vclk;

  // Known-answer pair for the test key, otherwise an arbitrary keyed mix
  function automatic logic [127:0] core_f(input logic [127:0] t, input logic [127:0] k, input logic d);
    if (!d && t == PT && k == K) return CT;
    if (d && t == CT && k == K) return PT;
    return t ^ {k[63:0], k[127:64]} ^ {128{d}};
  endfunction

  // AES core stand-in: answers each load after DELAY cycles; can inject a stray done
  logic         pend = 1'b0;
  int           cnt = 0;
  logic [127:0] m_text, m_key;
  logic         m_dec;
  always begin
    @(posedge vclk); #2;
    core_done = 1'b0;
    if (irq) irq_seen = 1'b1;
    if (!vrstn) pend = 1'b0;
    else if (core_ld) begin
      ld_count++;
      m_text = core_text_in; m_key = core_key; m_dec = core_dec;
      cnt = DELAY; pend = 1'b1;
    end else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        core_done = 1'b1;
        core_text_out = core_f(m_text, m_key, m_dec);
        pend = 1'b0;
      end
    end else if (inject_ack != inject_req) begin
      inject_ack++;
      core_done = 1'b1;
      core_text_out = {4{32'hdeadbeef}};
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    vpsel = 8'h01; vpaddr = a; vpwdata = d; vpwrite = 1'b1; vpenable = 1'b0;
    @(negedge vclk); vpenable = 1'b1;
    @(negedge vclk); vpsel = '0; vpenable = 1'b0; vpwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    vpsel = 8'h01; vpaddr = a; vpwrite = 1'b0; vpenable = 1'b0;
    #1 d = vprdata;
    @(negedge vclk); vpsel = '0;
  endtask

  task automatic write128(input logic [31:0] base, input logic [127:0] v);
    apb_write(base, v[127:96]); apb_write(base + 4, v[95:64]);
    apb_write(base + 8, v[63:32]); apb_write(base + 12, v[31:0]);
  endtask

  task automatic read128(input logic [31:0] base, output logic [127:0] v);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      apb_read(base + 32'(4 * i), w);
      v[127 - 32 * i -: 32] = w;
    end
  endtask

  task automatic start_op(input logic [31:0] ctrl, input logic [127:0] text, input logic dec,
                          input logic [127:0] dout, input bit push_dout);
    ld_exp_t e;
    e.text = text; e.key = K; e.dec = dec;
    ld_exp_q.push_back(e);
    if (push_dout) dout_exp_q.push_back(dout);
    apb_write(A_CTRL, ctrl);
    check("core_ld_after_start", core_ld, 1'b1);
    if (core_ld === 1'b1 && ld_exp_q.size() > 0) begin
      e = ld_exp_q.pop_front();
      check("core_text_in", core_text_in, e.text);
      check("core_key", core_key, e.key);
      check("core_dec", core_dec, e.dec);
    end
    @(negedge vclk);
    check("core_ld_single", core_ld, 1'b0);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0]  s;
    logic [127:0] d, exp;
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      apb_read(A_STATUS, s);
      if (!s[0] && s[1]) begin ok = 1; break; end
    end
    check($sformatf("%s_complete", tag), 128'(ok), 128'(1));
    if (dout_exp_q.size() > 0) begin
      exp = dout_exp_q.pop_front();
      read128(A_DOUT, d);
      check($sformatf("%s_dout", tag), d, exp);
    end
  endtask

  initial begin
    logic [31:0]  r;
    logic [127:0] v, mix;
    int n0;
    bit seen;

    repeat (3) @(negedge vclk);
    check("rst_core_ld", core_ld, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_prdata", vprdata, 32'h0);
    vrstn = 1'b1;
    @(negedge vclk);
    apb_read(A_STATUS, r); check("rst_status", r, 32'h0);
    apb_read(A_CTRL, r);   check("rst_ctrl", r, 32'h0);
    read128(A_DOUT, v);    check("rst_dout", v, 128'h0);

    // ECB encrypt on context 0
    write128(32'h00, K);
    write128(A_DIN, PT);
    start_op(32'h01, PT, 1'b0, CT, 1);
    wait_done("ecb");
    apb_read(A_STATUS, r); check("ecb_status", r, 32'h2);
    vpsel = 8'h02; vpaddr = A_DIN; #1 check("unselected_read", vprdata, 32'h0);
    vpsel = '0; @(negedge vclk);
    apb_read(32'hA8, r); check("unmapped_read", r, 32'h0);

    // CBC encrypt chaining on context 1
    write128(32'h20, K);
    write128(32'h30, 128'h0);
    start_op(32'h15, PT, 1'b0, CT, 1);
    wait_done("cbc_enc1");
    read128(32'h30, v); check("cbc_enc_iv1", v, CT);
    apb_read(A_CTRL, r); check("ctrl_readback", r, 32'h14);
    mix = core_f(PT ^ CT, K, 1'b0);
    start_op(32'h15, PT ^ CT, 1'b0, mix, 1);
    wait_done("cbc_enc2");
    read128(32'h30, v); check("cbc_enc_iv1_chain", v, mix);

    // CBC decrypt on context 0
    write128(A_DIN, CT);
    write128(32'h10, 128'h0);
    start_op(32'h07, CT, 1'b1, PT, 1);
    wait_done("cbc_dec");
    read128(32'h10, v); check("cbc_dec_iv0", v, CT);

    // Protected writes while busy
    apb_write(A_STATUS, 32'h6);
    write128(A_DIN, PT);
    n0 = ld_count;
    start_op(32'h01, PT, 1'b0, CT, 1);
    apb_write(32'h20, 32'h11111111);
    apb_write(A_CTRL, 32'h01);
    apb_write(A_DIN, 32'hffffffff);
    apb_write(32'h00, 32'h22222222);
    wait_done("busy_err");
    apb_read(A_STATUS, r); check("busy_err_status", r, 32'h6);
    check("busy_single_ld", 128'(ld_count - n0), 128'(1));
    apb_read(A_DIN, r);  check("busy_din_kept", r, PT[127:96]);
    apb_read(32'h00, r); check("busy_key_kept", r, K[127:96]);
    apb_read(32'h20, r); check("busy_other_ctx_key", r, 32'h11111111);
    apb_write(A_STATUS, 32'h4);
    apb_read(A_STATUS, r); check("err_w1c", r, 32'h2);
    n0 = ld_count;
    apb_write(A_CTRL, 32'h31);
    check("bad_ctx_no_ld", core_ld, 1'b0);
    apb_read(A_STATUS, r); check("bad_ctx_status", r, 32'h6);
    check("bad_ctx_ld_count", 128'(ld_count - n0), 128'(0));
    apb_write(A_STATUS, 32'h6);
    apb_read(A_STATUS, r); check("status_cleared", r, 32'h0);

    // DONE clear colliding with the completion edge
    start_op(32'h01, PT, 1'b0, CT, 1);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (core_done) begin seen = 1; break; end
      @(negedge vclk);
    end
    check("race_core_done_seen", 128'(seen), 128'(1));
    apb_write(A_STATUS, 32'h2);
    apb_read(A_STATUS, r); check("race_done_wins", r, 32'h2);
    wait_done("race");

    // Reset during WAIT aborts the operation
    start_op(32'h01, PT, 1'b0, CT, 0);
    vrstn = 1'b0;
    @(negedge vclk);
    check("abort_ld", core_ld, 1'b0);
    @(negedge vclk);
    vrstn = 1'b1;
    @(negedge vclk);
    apb_read(A_STATUS, r); check("abort_status", r, 32'h0);
    apb_read(32'h00, r);   check("abort_key0", r, 32'h0);
    apb_read(32'h30, r);   check("abort_iv1", r, 32'h0);
    apb_read(A_DIN, r);    check("abort_din", r, 32'h0);
    apb_read(A_CTRL, r);   check("abort_ctrl", r, 32'h0);
    n0 = ld_count;
    inject_req++;
    repeat (4) @(negedge vclk);
    apb_read(A_STATUS, r); check("stray_done_status", r, 32'h0);
    read128(A_DOUT, v);    check("stray_done_dout", v, 128'h0);
    check("stray_done_no_ld", 128'(ld_count - n0), 128'(0));

`ifdef AES_CBC_IRQ_EN
    write128(32'h00, K);
    write128(A_DIN, PT);
    start_op(32'h101, PT, 1'b0, CT, 1);
    wait_done("irq_op");
    check("irq_set", irq, 1'b1);
    apb_write(A_STATUS, 32'h2);
    check("irq_hold_one_cycle", irq, 1'b1);
    @(negedge vclk);
    check("irq_cleared", irq, 1'b0);
    check("irq_seen", irq_seen, 1'b1);
`else
    check("irq_never_asserted", irq_seen, 1'b0);
`endif

    if (ld_exp_q.size() != 0) check("ld_queue_drained", 128'(ld_exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
